// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the iterative inverse cipher.
//   state_t   : 16-byte cipher state. Byte n (FIPS numbering, column-major,
//               bytes 0-3 = column 0) lives in element [15-n], so the packed
//               value matches the 128-bit bus where byte 0 is bits [127:120].
//   fsm_e     : controller states of aes_decrypt_iter.
//   RCON      : key-schedule round constants, indexed by i/Nk (entry 0 unused).
//   sbox / inv_sbox : forward and inverse S-box lookups.
//   xtime / gf_mul  : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1 (0x11B).
//   sub_word  : S-box applied to each byte of a 32-bit key word.
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [15:0][7:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_DEC
    } fsm_e;

    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Table row selected by the high nibble; low nibble picks the byte,
    // leftmost byte of each row is entry x0.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [127:0] row;
        case (a[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[127 - 8 * int'(a[3:0]) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [127:0] row;
        case (a[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            default: row = 128'h172b047eba77d626e169146355210c7d;
        endcase
        return row[127 - 8 * int'(a[3:0]) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant b this folds to a few XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round
// One combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when
//   last_round_i is high).
// Ports:
//   state_i      : round input state (byte n in element [15-n])
//   rk_i         : 128-bit round key, byte 0 in bits [127:120]
//   last_round_i : 1 for round 0, suppresses InvMixColumns
//   state_o      : round output state
// ---------------------------------------------------------------------------
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t       state_i,
    input  logic [127:0] rk_i,
    input  logic         last_round_i,
    output state_t       state_o
);

    state_t     sub_s;
    state_t     ark_s;
    state_t     mix_s;
    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        sub_s = '0;
        // Row r is rotated right by r: out[r][c] = in[r][(c - r) mod 4].
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_s[15 - (4 * c + r)] = inv_sbox(state_i[15 - (4 * ((c - r + 4) % 4) + r)]);
            end
        end
        ark_s = sub_s ^ rk_i;
    end

    always_comb begin
        mix_s = '0;
        a0    = '0;
        a1    = '0;
        a2    = '0;
        a3    = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = ark_s[15 - 4 * c];
            a1 = ark_s[14 - 4 * c];
            a2 = ark_s[13 - 4 * c];
            a3 = ark_s[12 - 4 * c];
            mix_s[15 - 4 * c] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            mix_s[14 - 4 * c] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            mix_s[13 - 4 * c] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            mix_s[12 - 4 * c] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    end

    assign state_o = last_round_i ? ark_s : mix_s;

endmodule

// File: rtl/aes_decrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_decrypt_iter
// Iterative AES inverse cipher for 128/192/256-bit keys (Nk = 4/6/8).
// After start the full key schedule is expanded on chip, one round key
// (four words) per clock, then the inverse rounds run one per clock.
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset (aborts any operation)
//   start    : one-cycle request, only honoured while idle
//   data_in  : ciphertext, captured with start
//   key_in   : cipher key, captured with start (byte 0 in the top bits)
//   data_out : plaintext, valid from done until the next completion/reset
//   busy     : high from the cycle after start until done
//   done     : one-cycle pulse when data_out is updated
// ---------------------------------------------------------------------------
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     data_in,
    input  logic [Nk*32-1:0] key_in,
    output logic [127:0]     data_out,
    output logic             busy,
    output logic             done
);

    localparam int NW = 4 * (Nr + 1);

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q;
    state_t       st_q;
    logic [31:0]  w_q [NW];
    logic [127:0] data_out_q;
    logic         done_q;

    logic [31:0]  kw [4];
    logic [127:0] rk;
    state_t       round_out;
    logic         last_round;

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (rst) fsm_q <= ST_IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE:   if (start) fsm_d = ST_KEYEXP;
            ST_KEYEXP: if (rnd_q == 4'(Nr)) fsm_d = ST_DEC;
            ST_DEC:    if (rnd_q == 4'd0) fsm_d = ST_IDLE;
            default:   fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (fsm_q != ST_IDLE);
    end

    // ---------------- key schedule: words 4r..4r+3 for r = rnd_q ----------------
    always_comb begin
        int          base;
        int          i;
        int          src;
        logic [31:0] prev;
        logic [31:0] temp;
        // rnd_q is 0 only outside key expansion; clamp keeps indices in range.
        base = (rnd_q == 4'd0) ? 4 : 4 * int'(rnd_q);
        prev = w_q[base - 1];
        for (int j = 0; j < 4; j++) begin
            i   = base + j;
            src = (i >= Nk) ? i - Nk : 0;
            if (i % Nk == 0)
                temp = sub_word({prev[23:0], prev[31:24]}) ^ {RCON[4'(i / Nk)], 24'h0};
            else if (Nk == 8 && i % Nk == 4)
                temp = sub_word(prev);
            else
                temp = prev;
            kw[j] = (i < Nk) ? w_q[i] : (w_q[src] ^ temp);
            prev  = kw[j];
        end
    end

    // ---------------- round key select and inverse round ----------------
    always_comb begin
        rk = '0;
        for (int r = 0; r <= Nr; r++) begin
            if (int'(rnd_q) == r) rk = {w_q[4 * r], w_q[4 * r + 1], w_q[4 * r + 2], w_q[4 * r + 3]};
        end
    end

    assign last_round = (rnd_q == 4'd0);

    aes_inv_round u_round (
        .state_i      (st_q),
        .rk_i         (rk),
        .last_round_i (last_round),
        .state_o      (round_out)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= '0;
            rnd_q      <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            for (int k = 0; k < NW; k++) w_q[k] <= '0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        st_q  <= data_in;
                        rnd_q <= 4'd1;
                        for (int k = 0; k < Nk; k++) w_q[k] <= key_in[(Nk - k) * 32 - 1 -: 32];
                    end
                end
                ST_KEYEXP: begin
                    // Key words 0..Nk-1 keep the loaded key.
                    for (int k = Nk; k < NW; k++) begin
                        if (int'(rnd_q) == k / 4) w_q[k] <= kw[k % 4];
                    end
                    // Counter parks at Nr so decryption starts with rk[Nr].
                    if (rnd_q != 4'(Nr)) rnd_q <= rnd_q + 4'd1;
                end
                ST_DEC: begin
                    if (rnd_q == 4'(Nr)) begin
                        st_q  <= st_q ^ rk;
                        rnd_q <= rnd_q - 4'd1;
                    end else begin
                        st_q <= round_out;
                        if (rnd_q == 4'd0) begin
                            data_out_q <= round_out;
                            done_q     <= 1'b1;
                        end else begin
                            rnd_q <= rnd_q - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_iter
// Bench for aes_decrypt_iter with three instances (Nk = 4, 6, 8).
// Expected plaintexts come from FIPS-197 constants and from a forward AES
// model (S-box derived from GF(2^8) inversion plus the affine map, round
// constants by repeated doubling): random plaintexts are encrypted by the
// model and the design must recover them.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_iter;

    logic clk;
    logic rst;

    logic         start_v [3];
    logic [127:0] din_v   [3];
    logic [255:0] key_v   [3];
    logic [127:0] dout_v  [3];
    logic         busy_v  [3];
    logic         done_v  [3];

    logic [127:0] dout0, dout1, dout2;
    logic         busy0, busy1, busy2;
    logic         done0, done1, done2;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] sb [256];

    aes_decrypt_iter #(.Nk(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .data_in(din_v[0]),
        .key_in(key_v[0][127:0]), .data_out(dout0), .busy(busy0), .done(done0)
    );
    aes_decrypt_iter #(.Nk(6)) u_dut6 (
        .clk(clk), .rst(rst), .start(start_v[1]), .data_in(din_v[1]),
        .key_in(key_v[1][191:0]), .data_out(dout1), .busy(busy1), .done(done1)
    );
    aes_decrypt_iter #(.Nk(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .data_in(din_v[2]),
        .key_in(key_v[2][255:0]), .data_out(dout2), .busy(busy2), .done(done2)
    );

    assign dout_v[0] = dout0;
    assign dout_v[1] = dout1;
    assign dout_v[2] = dout2;
    assign busy_v[0] = busy0;
    assign busy_v[1] = busy1;
    assign busy_v[2] = busy2;
    assign done_v[0] = done0;
    assign done_v[1] = done1;
    assign done_v[2] = done2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
        for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [255:0] key, input int nk);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[32 * (nk - i) - 1 -: 32];
            end else begin
                tmp = w[i - 1];
                if (i % nk == 0) begin
                    tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                    rc  = gm(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    tmp = subw(tmp);
                end
                w[i] = w[i - nk] ^ tmp;
            end
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127 - 8 * n -: 8] ^ w[n / 4][31 - 8 * (n % 4) -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int n = 0; n < 16; n++) s[n] = sb[s[n]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4 * c + r] = s[4 * ((c + r) % 4) + r];
            for (int c = 0; c < 4; c++) begin
                if (rd != nr) begin
                    s[4*c]   = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
                    s[4*c+3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4 * rd + n / 4][31 - 8 * (n % 4) -: 8];
        end
        for (int n = 0; n < 16; n++) res[127 - 8 * n -: 8] = s[n];
        return res;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts one decryption on instance k in the current cycle and follows it
    // to done. With tail set, also checks the cycle after done.
    task automatic run_op(input int k, input logic [127:0] ct, input logic [255:0] key,
                          input logic [127:0] exp, input string tag, input bit glitch, input bit tail);
        int           n;
        int           lat;
        bit           busy_ok;
        bit           hold_ok;
        logic [127:0] held;
        lat        = 2 * (10 + 2 * k) + 1;
        held       = dout_v[k];
        din_v[k]   = ct;
        key_v[k]   = key;
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        check({tag, ".busy_after_start"}, 256'(busy_v[k]), 256'(1));
        n       = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (n < 100) begin
            if (glitch && n == 4) begin
                start_v[k] = 1'b1;
                din_v[k]   = ~ct;
            end else begin
                start_v[k] = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done_v[k] === 1'b1) break;
            if (busy_v[k] !== 1'b1) busy_ok = 1'b0;
            if (dout_v[k] !== held) hold_ok = 1'b0;
        end
        start_v[k] = 1'b0;
        check({tag, ".latency"},      256'(n), 256'(lat));
        check({tag, ".data_out"},     256'(dout_v[k]), 256'(exp));
        check({tag, ".busy_at_done"}, 256'(busy_v[k]), 256'(0));
        check({tag, ".busy_held"},    256'(busy_ok), 256'(1));
        check({tag, ".dout_held"},    256'(hold_ok), 256'(1));
        if (tail) begin
            @(posedge clk); #1;
            check({tag, ".done_pulse"}, 256'(done_v[k]), 256'(0));
            check({tag, ".dout_after"}, 256'(dout_v[k]), 256'(exp));
        end
    endtask

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY4 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY6 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] KEY8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        logic [255:0] rkey;
        logic [127:0] rpt;
        logic [127:0] rct;
        logic [127:0] ct2;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            din_v[k]   = '0;
            key_v[k]   = '0;
        end
        build_sbox();

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset.dout%0d", k), 256'(dout_v[k]), 256'(0));
            check($sformatf("reset.busy%0d", k), 256'(busy_v[k]), 256'(0));
            check($sformatf("reset.done%0d", k), 256'(done_v[k]), 256'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 appendix C vectors
        run_op(0, CT4, KEY4, PT_FIPS, "fips_nk4", 1'b0, 1'b1);
        run_op(1, CT6, KEY6, PT_FIPS, "fips_nk6", 1'b0, 1'b1);
        run_op(2, CT8, KEY8, PT_FIPS, "fips_nk8", 1'b0, 1'b1);

        // start pulsed mid-operation with different data must be ignored
        run_op(0, CT4, KEY4, PT_FIPS, "ignore_start", 1'b1, 1'b1);

        // reset ten edges into an operation
        din_v[0]   = CT4;
        key_v[0]   = KEY4;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset.dout", 256'(dout_v[0]), 256'(0));
        check("midreset.busy", 256'(busy_v[0]), 256'(0));
        check("midreset.done", 256'(done_v[0]), 256'(0));
        @(posedge clk); #1;
        check("midreset.idle_done", 256'(done_v[0]), 256'(0));
        run_op(0, CT4, KEY4, PT_FIPS, "after_reset", 1'b0, 1'b1);

        // back-to-back: second start issued in the done cycle of the first
        ct2 = encrypt(CT4, KEY4, 4);
        run_op(0, CT4, KEY4, PT_FIPS, "b2b_first", 1'b0, 1'b0);
        run_op(0, ct2, KEY4, CT4, "b2b_second", 1'b0, 1'b1);

        // random blocks and keys checked through the forward model
        for (int k = 0; k < 3; k++) begin
            for (int it = 0; it < 3; it++) begin
                rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                rpt  = {$urandom, $urandom, $urandom, $urandom};
                rct  = encrypt(rpt, rkey, 4 + 2 * k);
                run_op(k, rct, rkey, rpt, $sformatf("rand_nk%0d_%0d", 4 + 2 * k, it), 1'b0, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
